// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer for the dual-issue front end.
//
// Owns the fetch PC and keeps at most one 2-word request outstanding on the
// instruction port. Returned words go straight into the instruction FIFO.
// Redirects flush the FIFO and retarget the PC. If a request is already in
// flight, its response is discarded. A misaligned PC produces a FIFO entry
// flagged with a fetch address error instead of a bus request.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   redirect_valid    one-cycle flush pulse; redirect_pc is the new fetch target
//   fifo_no_room      FIFO has fewer than 2 free entries
//   inst_data_ok      response strobe; inst_data_ok1/2 qualify word 0/1
//   inst_req          request outstanding, held until inst_data_ok
//   inst_addr         request PC, stable while inst_req is high
//   fifo_rst          clear the FIFO (same cycle as redirect_valid)
//   fifo_we1/2        write enables for slot 1/2
//   fifo_waddr1/2     PCs for slot 1/2
//   fifo_wexp1        slot-1 exception field; bit 0 = fetch address error
//   busy              FSM is not idle
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned EXP_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             fifo_no_room,
    input  logic             inst_data_ok,
    input  logic             inst_data_ok1,
    input  logic             inst_data_ok2,
    output logic             inst_req,
    output logic [31:0]      inst_addr,
    output logic             fifo_rst,
    output logic             fifo_we1,
    output logic             fifo_we2,
    output logic [31:0]      fifo_waddr1,
    output logic [31:0]      fifo_waddr2,
    output logic [EXP_W-1:0] fifo_wexp1,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDrop} state_e;

    state_e      state;
    logic [31:0] pc;
    logic [31:0] target;  // redirect target held while a dropped response is pending
    logic        misaligned;

    assign misaligned = (pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            pc     <= RESET_PC;
            target <= RESET_PC;
        end else if (redirect_valid) begin
            unique case (state)
                StIdle, StIssue: begin
                    pc    <= redirect_pc;
                    state <= StIssue;
                end
                StWait: begin
                    if (inst_data_ok) begin
                        pc    <= redirect_pc;
                        state <= StIssue;
                    end else begin
                        target <= redirect_pc;
                        state  <= StDrop;
                    end
                end
                StDrop: begin
                    target <= redirect_pc;
                    if (inst_data_ok) begin
                        pc    <= redirect_pc;
                        state <= StIssue;
                    end
                end
                default: state <= StIdle;
            endcase
        end else begin
            unique case (state)
                StIdle: state <= StIssue;
                StIssue: begin
                    // Misaligned PC never issues; it sits here until a redirect.
                    if (!misaligned && !fifo_no_room) begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (inst_data_ok) begin
                        // Word 2 without word 1 is a protocol error and is ignored.
                        if (inst_data_ok1 && inst_data_ok2) begin
                            pc <= pc + 32'd8;
                        end else if (inst_data_ok1) begin
                            pc <= pc + 32'd4;
                        end
                        state <= StIssue;
                    end
                end
                StDrop: begin
                    if (inst_data_ok) begin
                        pc    <= target;
                        state <= StIssue;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Request line is a pure decode of the state register.
    assign inst_req    = (state == StWait) || (state == StDrop);
    assign inst_addr   = pc;
    assign fifo_rst    = redirect_valid;
    assign fifo_waddr1 = pc;
    assign fifo_waddr2 = pc + 32'd4;
    assign busy        = (state != StIdle);

    always_comb begin
        fifo_we1   = 1'b0;
        fifo_we2   = 1'b0;
        fifo_wexp1 = '0;
        if (state == StIssue && misaligned) begin
            fifo_wexp1[0] = 1'b1;
        end
        if (!redirect_valid) begin
            unique case (state)
                StIssue: begin
                    if (misaligned && !fifo_no_room) begin
                        fifo_we1 = 1'b1;
                    end
                end
                StWait: begin
                    if (inst_data_ok) begin
                        fifo_we1 = inst_data_ok1;
                        fifo_we2 = inst_data_ok1 && inst_data_ok2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed, self-checking bench for fetch_ctrl.
// Expected FIFO writes are queued when a response is driven and popped by a
// monitor whenever the DUT asserts a write enable.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fifo_no_room = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic        inst_data_ok1 = 1'b0;
    logic        inst_data_ok2 = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        fifo_rst;
    logic        fifo_we1;
    logic        fifo_we2;
    logic [31:0] fifo_waddr1;
    logic [31:0] fifo_waddr2;
    logic [11:0] fifo_wexp1;
    logic        busy;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_PC(32'hBFC0_0000),
        .EXP_W   (12)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fifo_no_room  (fifo_no_room),
        .inst_data_ok  (inst_data_ok),
        .inst_data_ok1 (inst_data_ok1),
        .inst_data_ok2 (inst_data_ok2),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .fifo_rst      (fifo_rst),
        .fifo_we1      (fifo_we1),
        .fifo_we2      (fifo_we2),
        .fifo_waddr1   (fifo_waddr1),
        .fifo_waddr2   (fifo_waddr2),
        .fifo_wexp1    (fifo_wexp1),
        .busy          (busy)
    );

    typedef struct packed {
        logic        we2;
        logic [31:0] addr;
        logic        exc;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (fifo_we1 || fifo_we2) begin
            n_cmp++;
            assert (exp_q.size() != 0)
            else begin
                n_bad++;
                $error("FAIL unexpected_write: observed write at %h expected none", fifo_waddr1);
            end
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_we1", 32'(fifo_we1), 32'd1);
                check("wr_we2", 32'(fifo_we2), 32'(e.we2));
                check("wr_addr1", fifo_waddr1, e.addr);
                check("wr_addr2", fifo_waddr2, e.addr + 32'd4);
                check("wr_exp", 32'(fifo_wexp1), 32'(e.exc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a request, then check its address.
    task automatic wait_req(input logic [31:0] a, input string tag);
        int n;
        n = 0;
        while (!inst_req && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 32'(inst_req), 32'd1);
        check({tag, "_addr"}, inst_addr, a);
    endtask

    // One-cycle response; queue the expected write when it should land.
    task automatic respond(input logic [31:0] a, input logic ok1, input logic ok2,
                           input logic push);
        inst_data_ok  = 1'b1;
        inst_data_ok1 = ok1;
        inst_data_ok2 = ok2;
        if (push && ok1) exp_q.push_back('{we2: ok2, addr: a, exc: 1'b0});
        tick();
        inst_data_ok  = 1'b0;
        inst_data_ok1 = 1'b0;
        inst_data_ok2 = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(inst_req), 32'd0);
        check("rst_addr", inst_addr, 32'hBFC0_0000);
        check("rst_fifo_rst", 32'(fifo_rst), 32'd0);
        check("rst_we1", 32'(fifo_we1), 32'd0);
        rst = 1'b0;

        // Sequential fetch with full and partial responses
        wait_req(32'hBFC0_0000, "seq0");
        respond(32'hBFC0_0000, 1'b1, 1'b1, 1'b1);
        wait_req(32'hBFC0_0008, "seq1");
        respond(32'hBFC0_0008, 1'b1, 1'b1, 1'b1);
        wait_req(32'hBFC0_0010, "seq2");
        respond(32'hBFC0_0010, 1'b1, 1'b1, 1'b1);
        wait_req(32'hBFC0_0018, "seq3");
        respond(32'hBFC0_0018, 1'b1, 1'b0, 1'b1);
        wait_req(32'hBFC0_001C, "seq4");
        respond(32'hBFC0_001C, 1'b1, 1'b0, 1'b1);
        wait_req(32'hBFC0_0020, "seq5");
        respond(32'hBFC0_0020, 1'b0, 1'b1, 1'b0);  // ok2 alone: no write, no advance
        wait_req(32'hBFC0_0020, "seq6");

        // Back-pressure in ISSUE
        fifo_no_room = 1'b1;
        respond(32'hBFC0_0020, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("noroom_req", 32'(inst_req), 32'd0);
            tick();
        end
        fifo_no_room = 1'b0;
        tick();
        check("room_req", 32'(inst_req), 32'd1);
        check("room_addr", inst_addr, 32'hBFC0_0028);
        respond(32'hBFC0_0028, 1'b1, 1'b1, 1'b1);

        // Redirect while waiting: response discarded
        wait_req(32'hBFC0_0030, "pre_drop");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1000;
        #1;
        check("drop_fifo_rst", 32'(fifo_rst), 32'd1);
        tick();
        redirect_valid = 1'b0;
        check("drop_req", 32'(inst_req), 32'd1);
        check("drop_addr", inst_addr, 32'hBFC0_0030);
        tick();
        tick();
        respond(32'hBFC0_0030, 1'b1, 1'b1, 1'b0);
        wait_req(32'h8000_1000, "post_drop");

        // Redirect coincident with data_ok
        inst_data_ok   = 1'b1;
        inst_data_ok1  = 1'b1;
        inst_data_ok2  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_2000;
        #1;
        check("coin_fifo_rst", 32'(fifo_rst), 32'd1);
        check("coin_we1", 32'(fifo_we1), 32'd0);
        check("coin_we2", 32'(fifo_we2), 32'd0);
        tick();
        inst_data_ok   = 1'b0;
        inst_data_ok1  = 1'b0;
        inst_data_ok2  = 1'b0;
        redirect_valid = 1'b0;
        wait_req(32'h8000_2000, "coin");

        // Two redirects: latest target wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_3000;
        tick();
        redirect_pc    = 32'h8000_4000;
        tick();
        redirect_valid = 1'b0;
        respond(32'h8000_2000, 1'b1, 1'b1, 1'b0);
        wait_req(32'h8000_4000, "latest");
        respond(32'h8000_4000, 1'b1, 1'b1, 1'b1);
        wait_req(32'h8000_4008, "latest_next");

        // Misaligned redirect target
        inst_data_ok   = 1'b1;
        inst_data_ok1  = 1'b1;
        inst_data_ok2  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0002;
        tick();
        inst_data_ok   = 1'b0;
        inst_data_ok1  = 1'b0;
        inst_data_ok2  = 1'b0;
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{we2: 1'b0, addr: 32'h8000_0002, exc: 1'b1});
            check("mis_req", 32'(inst_req), 32'd0);
            tick();
        end
        fifo_no_room = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("mis_noroom_we1", 32'(fifo_we1), 32'd0);
            tick();
        end

        // PC wrap at the top of the address space
        fifo_no_room   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        wait_req(32'hFFFF_FFF8, "wrap");
        respond(32'hFFFF_FFF8, 1'b1, 1'b1, 1'b1);
        wait_req(32'h0000_0000, "wrapped");

        // Reset in the middle of a request
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_req", 32'(inst_req), 32'd0);
        check("midrst_addr", inst_addr, 32'hBFC0_0000);
        wait_req(32'hBFC0_0000, "after_rst");
        respond(32'hBFC0_0000, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
